// File: rtl/quad_enc_pkg.sv
// -----------------------------------------------------------------------------
// quad_enc_pkg
// Shared definitions for the quadrature encoder emulator and its consumers.
//   STEP_0..STEP_3 : the four Gray-coded {B,A} phases in forward order
//   state_t        : generator state encoding (IDLE / RUN_CONT / RUN_BURST)
//   next_phase()   : one position forward along the Gray sequence
//   prev_phase()   : one position backward along the Gray sequence
// -----------------------------------------------------------------------------
package quad_enc_pkg;

    localparam logic [1:0] STEP_0 = 2'b00;
    localparam logic [1:0] STEP_1 = 2'b01;
    localparam logic [1:0] STEP_2 = 2'b11;
    localparam logic [1:0] STEP_3 = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RUN_CONT  = 2'b01,
        RUN_BURST = 2'b10
    } state_t;

    // Forward neighbour: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] next_phase(input logic [1:0] p);
        case (p)
            STEP_0:  return STEP_1;
            STEP_1:  return STEP_2;
            STEP_2:  return STEP_3;
            STEP_3:  return STEP_0;
            default: return STEP_0;
        endcase
    endfunction

    // Reverse neighbour: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] prev_phase(input logic [1:0] p);
        case (p)
            STEP_0:  return STEP_3;
            STEP_3:  return STEP_2;
            STEP_2:  return STEP_1;
            STEP_1:  return STEP_0;
            default: return STEP_0;
        endcase
    endfunction

endpackage

// File: rtl/quad_enc_gen_step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Free-running period counter with synchronous clear and enable. Counts
// 0..period-1 while enabled and raises tick during the cycle in which the
// count sits at period-1, so the consumer acts on exactly every period-th
// enabled edge. A period of 0 never ticks and holds the count.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear to 0 (has priority over counting)
//   en         : count enable; low freezes the count
//   period     : clocks per tick
//   tick       : combinational, high when the next enabled edge ends a period
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] P_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] P_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0] r_timer;
    logic                w_at_end;

    assign w_at_end = (period != P_ZERO) && (r_timer == (period - P_ONE));
    assign tick     = en & w_at_end;

    // Period counter: clear, wrap at period-1, or hold when disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= P_ZERO;
        end else if (clr) begin
            r_timer <= P_ZERO;
        end else if (en && (period != P_ZERO)) begin
            if (w_at_end) begin
                r_timer <= P_ZERO;
            end else begin
                r_timer <= r_timer + P_ONE;
            end
        end else begin
            r_timer <= r_timer;
        end
    end

endmodule

// File: rtl/quad_enc_gen.sv
// -----------------------------------------------------------------------------
// quad_enc_gen
// Quadrature encoder emulator: produces a Gray-coded {B,A} pattern at a
// commanded rate and direction, either continuously or for a fixed burst.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   en          : run gate; low freezes timer, phase and burst count
//   cmd_load    : one-cycle strobe latching cmd_dir/cmd_period/cmd_steps
//   cmd_dir     : 1 forward (00,01,11,10), 0 reverse (00,10,11,01)
//   cmd_period  : clocks per step, 0 halts stepping while staying in RUN
//   cmd_steps   : burst length, 0 runs continuously
//   enc         : registered {B,A}
//   step        : one-cycle pulse in the cycle enc takes a new value
//   pos_count   : signed step position, wraps in two's complement
//   busy        : high while running (continuous or burst)
//   done        : one-cycle pulse when a burst finishes
// -----------------------------------------------------------------------------
module quad_enc_gen
    import quad_enc_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                cmd_load,
    input  logic                cmd_dir,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic [CNT_W-1:0]    cmd_steps,
    output logic [1:0]          enc,
    output logic                step,
    output logic [CNT_W-1:0]    pos_count,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [1:0]          r_enc;
    logic                r_step;
    logic [CNT_W-1:0]    r_pos;
    logic                r_busy;
    logic                r_done;
    logic                r_dir;
    logic [PERIOD_W-1:0] r_period;
    logic [CNT_W-1:0]    r_remaining;

    logic                w_timer_en;
    logic                w_tick;

    // The timer only runs while a RUN state is active and the gate is open
    assign w_timer_en = en & (r_state != IDLE);

    step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (cmd_load),
        .en     (w_timer_en),
        .period (r_period),
        .tick   (w_tick)
    );

    // Generator FSM with registered outputs; a load always beats a step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_enc       <= STEP_0;
            r_step      <= 1'b0;
            r_pos       <= CNT_ZERO;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dir       <= 1'b0;
            r_period    <= {PERIOD_W{1'b0}};
            r_remaining <= CNT_ZERO;
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            if (cmd_load) begin
                // Phase and position carry over so a direction change stays
                // a single-bit transition; an aborted burst gives no done.
                r_dir       <= cmd_dir;
                r_period    <= cmd_period;
                r_remaining <= cmd_steps;
                r_busy      <= 1'b1;
                if (cmd_steps == CNT_ZERO) begin
                    r_state <= RUN_CONT;
                end else begin
                    r_state <= RUN_BURST;
                end
            end else if (w_tick) begin
                r_step <= 1'b1;
                if (r_dir) begin
                    r_enc <= next_phase(r_enc);
                    r_pos <= r_pos + CNT_ONE;
                end else begin
                    r_enc <= prev_phase(r_enc);
                    r_pos <= r_pos - CNT_ONE;
                end
                case (r_state)
                    RUN_BURST: begin
                        r_remaining <= r_remaining - CNT_ONE;
                        if (r_remaining == CNT_ONE) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN_BURST;
                        end
                    end
                    RUN_CONT: begin
                        r_state <= RUN_CONT;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign enc       = r_enc;
    assign step      = r_step;
    assign pos_count = r_pos;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_quad_enc_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_enc_gen
// Directed bench: a table of command scenarios (each from a fresh reset)
// plus hand-written cycle-accurate sequences for latency, gating, reload on
// a step boundary, burst abort and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_quad_enc_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic        cmd_load;
    logic        cmd_dir;
    logic [15:0] cmd_period;
    logic [15:0] cmd_steps;
    logic [1:0]  enc;
    logic        step;
    logic [15:0] pos_count;
    logic        busy;
    logic        done;

    int n_chk;
    int n_fail;

    quad_enc_gen #(
        .PERIOD_W (16),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cmd_load   (cmd_load),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .cmd_steps  (cmd_steps),
        .enc        (enc),
        .step       (step),
        .pos_count  (pos_count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dir;
        logic [15:0] period;
        logic [15:0] steps;
        int          ncyc;
        logic [1:0]  enc;
        logic [15:0] pos;
        int          nstep;
        logic        busy;
        int          ndone;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic do_load(input logic d, input logic [15:0] p, input logic [15:0] s);
        cmd_dir    = d;
        cmd_period = p;
        cmd_steps  = s;
        cmd_load   = 1'b1;
        cyc();
        cmd_load   = 1'b0;
    endtask

    initial begin
        int nstep;
        int ndone;
        int bad;
        int nbusy_lo;
        logic [1:0] prev;

        n_chk  = 0;
        n_fail = 0;
        reset = 1'b1; en = 1'b1; cmd_load = 1'b0; cmd_dir = 1'b0;
        cmd_period = 16'd0; cmd_steps = 16'd0;

        //           dir   period  steps   ncyc enc    pos       nstep busy ndone
        tbl[0] = '{1'b1, 16'd4, 16'd0,  16,  2'b00, 16'h0004, 4,  1'b1, 0};
        tbl[1] = '{1'b0, 16'd2, 16'd0,  8,   2'b00, 16'hFFFC, 4,  1'b1, 0};
        tbl[2] = '{1'b1, 16'd3, 16'd10, 30,  2'b11, 16'h000A, 10, 1'b0, 1};
        tbl[3] = '{1'b0, 16'd1, 16'd3,  5,   2'b01, 16'hFFFD, 3,  1'b0, 1};
        tbl[4] = '{1'b1, 16'd5, 16'd0,  9,   2'b01, 16'h0001, 1,  1'b1, 0};
        tbl[5] = '{1'b1, 16'd0, 16'd0,  100, 2'b00, 16'h0000, 0,  1'b1, 0};

        // Reset state
        do_reset();
        chk("rst_enc",  {30'd0, enc},  32'd0);
        chk("rst_pos",  {16'd0, pos_count}, 32'd0);
        chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Table-driven scenarios
        for (int r = 0; r < 6; r++) begin
            do_reset();
            do_load(tbl[r].dir, tbl[r].period, tbl[r].steps);
            nstep = 0; ndone = 0; bad = 0;
            prev = enc;
            for (int c = 0; c < tbl[r].ncyc; c++) begin
                cyc();
                if (step) nstep++;
                if (done) ndone++;
                if ((enc != prev) && (((enc[0] ^ prev[0]) + (enc[1] ^ prev[1])) != 1)) bad++;
                if ((enc != prev) && !step) bad++;
                prev = enc;
            end
            chk($sformatf("tbl%0d_enc", r),   {30'd0, enc}, {30'd0, tbl[r].enc});
            chk($sformatf("tbl%0d_pos", r),   {16'd0, pos_count}, {16'd0, tbl[r].pos});
            chk($sformatf("tbl%0d_nstep", r), nstep, tbl[r].nstep);
            chk($sformatf("tbl%0d_busy", r),  {31'd0, busy}, {31'd0, tbl[r].busy});
            chk($sformatf("tbl%0d_ndone", r), ndone, tbl[r].ndone);
            chk($sformatf("tbl%0d_gray", r),  bad, 0);
        end

        // First-step latency: period 4 -> first change on 4th edge after load
        do_reset();
        do_load(1'b1, 16'd4, 16'd0);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("lat_step%0d", i), {31'd0, step}, {31'd0, (i == 4)});
            chk($sformatf("lat_enc%0d", i),  {30'd0, enc}, (i == 4) ? 32'd1 : 32'd0);
        end
        chk("lat_pos", {16'd0, pos_count}, 32'd1);

        // en low mid-period freezes everything; partial period resumes
        cyc();
        cyc();
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (step || (enc != 2'b01)) bad++;
        end
        chk("gate_frozen", bad, 0);
        en = 1'b1;
        cyc();
        chk("gate_resume1_step", {31'd0, step}, 32'd0);
        cyc();
        chk("gate_resume2_step", {31'd0, step}, 32'd1);
        chk("gate_resume2_enc",  {30'd0, enc}, 32'd3);
        chk("gate_resume2_pos",  {16'd0, pos_count}, 32'd2);

        // Reload in reverse exactly on a step boundary: load wins
        cyc();
        cyc();
        cyc();
        cmd_dir = 1'b0; cmd_period = 16'd2; cmd_steps = 16'd0; cmd_load = 1'b1;
        cyc();
        cmd_load = 1'b0;
        chk("bnd_step", {31'd0, step}, 32'd0);
        chk("bnd_enc",  {30'd0, enc}, 32'd3);
        chk("bnd_pos",  {16'd0, pos_count}, 32'd2);
        cyc();
        chk("rev1_step", {31'd0, step}, 32'd0);
        cyc();
        chk("rev2_step", {31'd0, step}, 32'd1);
        chk("rev2_enc",  {30'd0, enc}, 32'd1);
        chk("rev2_pos",  {16'd0, pos_count}, 32'd1);

        // Reload during a burst aborts it with no done pulse
        do_reset();
        do_load(1'b1, 16'd2, 16'd3);
        for (int i = 0; i < 4; i++) cyc();
        chk("abort_pre_pos", {16'd0, pos_count}, 32'd2);
        do_load(1'b1, 16'd2, 16'd0);
        ndone = 0; nbusy_lo = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (done) ndone++;
            if (!busy) nbusy_lo++;
        end
        chk("abort_ndone",   ndone, 0);
        chk("abort_busy_lo", nbusy_lo, 0);
        chk("abort_pos",     {16'd0, pos_count}, 32'd7);

        // Asynchronous reset mid-burst
        do_reset();
        do_load(1'b1, 16'd1, 16'd50);
        for (int i = 0; i < 5; i++) cyc();
        chk("areset_pre_pos", {16'd0, pos_count}, 32'd5);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_enc",  {30'd0, enc}, 32'd0);
        chk("areset_pos",  {16'd0, pos_count}, 32'd0);
        chk("areset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0; bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (done) ndone++;
            if ((enc != 2'b00) || busy) bad++;
        end
        chk("areset_ndone", ndone, 0);
        chk("areset_idle",  bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_enc_gen.md
Name: quad_enc_gen

Overview:
Quadrature encoder emulator that drives a 2-bit A/B pattern in place of a physical motor encoder. It accepts a commanded direction, step period and optional step count. It is the transmit counterpart of measure_speed. The block drives measure_speed for hardware-in-the-loop speed-loop bring-up and self-test without a motor attached.

Parameters:
PERIOD_W, 16, width of cmd_period (clock cycles per quadrature step)
CNT_W, 16, width of cmd_steps and pos_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  run gate; low freezes timer and phase, state retained
cmd_load  input  1  single-cycle strobe; latches cmd_dir/cmd_period/cmd_steps and (re)starts generation
cmd_dir  input  1  1 = forward (00→01→11→10), 0 = reverse (00→10→11→01)
cmd_period  input  PERIOD_W  clocks per step; 0 = halt (no steps, stays in RUN state)
cmd_steps  input  CNT_W  burst length; 0 = continuous
enc  output  2  registered quadrature output {B,A}
step  output  1  one-cycle pulse, asserted in the same cycle enc takes a new value
pos_count  output  CNT_W  signed step position; +1 forward, -1 reverse; two's-complement wrap
busy  output  1  high in RUN_CONT or RUN_BURST
done  output  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (async, active-high): enc=2'b00, pos_count=0, step=0, done=0, busy=0, state=IDLE, timer=0, latched period/dir/steps cleared.
- States:
  - IDLE: entered on reset or burst completion.
  - RUN_CONT: entered on cmd_load with cmd_steps==0.
  - RUN_BURST: entered on cmd_load with cmd_steps!=0.
- cmd_load is accepted in any state, including mid-run.
- There is no return to IDLE from RUN_CONT except via reset or a new burst load.
- Timer: cleared to 0 on cmd_load.
  - In a RUN state with en=1 and period_q!=0: timer increments.
  - When timer==period_q-1: timer returns to 0 and a step is issued on the next edge.
- Latency: first enc change occurs exactly period_q enabled clock edges after the edge that sampled cmd_load. Successive steps follow every period_q enabled clocks. period_q=1 gives a step every clock.
- Step: phase advances one position in dir_q along the Gray sequence, so exactly one enc bit toggles per step. pos_count is updated the same edge; step=1 for that one cycle.
- Direction change: a reload with the opposite dir continues from the current phase; no reset to 00 and no double-bit transition.
- Burst: remaining counter is loaded with cmd_steps and decremented per step. On the step that takes it to 0:
  - state→IDLE, done=1 for that cycle, busy falls on the same edge.
  - enc holds its final phase.
- en=0: timer, phase and remaining count are frozen; step is not asserted. Resuming continues the partial period.
- cmd_load coincident with a step boundary: the load wins. No step is issued on that edge, and the new parameters and timer=0 take effect.
- cmd_load while in RUN_BURST aborts the burst without a done pulse.
- pos_count, enc and phase are never cleared by cmd_load; only reset clears them.
- Reset asserted mid-run returns all outputs to reset values asynchronously.

Decomposition:
- Shared package quad_enc_pkg holds:
  - STEP_0..STEP_3 (2'b00, 2'b01, 2'b11, 2'b10)
  - next/prev phase functions
  - state encoding IDLE/RUN_CONT/RUN_BURST
- The same package is imported by measure_speed benches.
- Sub-module step_timer (period counter with clear/enable, emits tick): kept separate so it can be reused for a PWM/tach generator.

Test Plan:
1. Reset released; cmd_load dir=1 period=4 steps=0, en=1 → enc 00→01→11→10→00 changing every 4 clocks; first change 4 clocks after the load edge; pos_count increments 1,2,3,4; step pulses 1 cycle each.
2. dir=0 period=2 steps=0 → enc 00→10→11→01→00; pos_count goes -1,-2,-3,-4 (0xFFFF…0xFFFC).
3. dir=1 period=3 steps=10 → exactly 10 step pulses over 30 clocks; done pulses once on the 10th; final enc=2'b11, pos_count=10, busy low afterwards.
4. Forward run, deassert en for 7 clocks mid-period → no enc change while low; remaining partial period completes after re-enable; no extra step.
5. Forward run at phase 11, reload dir=0 period=2 → next enc is 01 (single-bit change); pos_count decrements; cmd_load on a boundary cycle produces no step that cycle.
6. period=0 load → busy=1, enc static for 100 clocks. Reset asserted mid-burst → enc=00, pos_count=0, busy=0 immediately, with no done pulse.
